// File: rtl/clk_gen_pkg.sv
// Shared constants, channel state type and divisor helpers for the clock divider.
// Helpers work on FN_W-bit values so any channel counter width up to FN_W fits.
package clk_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int FN_W      = 32;
  localparam logic [FN_W-1:0] MIN_DIV = 32'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  function automatic logic [FN_W-1:0] sanitize_div(input logic [FN_W-1:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // ceil(d/2) with one extra bit so the all-ones divisor cannot overflow
  function automatic logic [FN_W:0] high_len(input logic [FN_W-1:0] d);
    return ({1'b0, d} + (FN_W+1)'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Control/status bundle between a divider bank and its user.
interface clk_div_gen_if
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*CNT_W-1:0] div;
  logic                    sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       active;

  modport master (
    output en, div, sync,
    input  clk_out, tick, active
  );

  modport slave (
    input  en, div, sync,
    output clk_out, tick, active
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, latched divisor, IDLE/RUN state and
// registered divided-clock level plus period-start tick.
module clk_div_ch
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_active
);

  ch_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_active_div, w_active_div_nxt;
  logic             r_clk_out, w_clk_out_nxt;
  logic             r_tick, w_tick_nxt;

  logic [FN_W-1:0]  w_ds_wide;
  logic [CNT_W-1:0] w_ds;
  logic [FN_W:0]    w_high;
  logic [FN_W:0]    w_cnt_inc;
  logic             w_wrap;

  assign w_ds_wide = sanitize_div(FN_W'(i_div));
  assign w_ds      = w_ds_wide[CNT_W-1:0];
  assign w_high    = high_len(FN_W'(r_active_div));
  assign w_cnt_inc = (FN_W+1)'(r_cnt) + (FN_W+1)'(1);
  assign w_wrap    = (r_cnt == r_active_div - CNT_W'(1));

  generate
    if (CNT_W < FN_W) begin : g_ds_pad
      logic w_unused_ds_pad;
      assign w_unused_ds_pad = ^w_ds_wide[FN_W-1:CNT_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_active_div <= CNT_W'(MIN_DIV);
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active_div <= w_active_div_nxt;
      r_clk_out    <= w_clk_out_nxt;
      r_tick       <= w_tick_nxt;
    end
  end

  // Disable beats sync, sync beats wrap; a new divisor is only taken at a period start.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_active_div_nxt = r_active_div;
    w_clk_out_nxt    = 1'b0;
    w_tick_nxt       = 1'b0;
    if (!i_en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == IDLE || i_sync || w_wrap) begin
      w_state_nxt      = RUN;
      w_cnt_nxt        = '0;
      w_active_div_nxt = w_ds;
      w_clk_out_nxt    = 1'b1;
      w_tick_nxt       = 1'b1;
    end else begin
      w_cnt_nxt     = w_cnt_inc[CNT_W-1:0];
      w_clk_out_nxt = (w_cnt_inc < w_high);
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_active  = (r_state == RUN);

endmodule

// File: rtl/clk_div_gen.sv
// Bank of NUM_CH independent programmable clock dividers sharing clk, rst and sync.
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_gen_if.slave  bus
);

  logic [NUM_CH-1:0] w_clk_out;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_active;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_ch #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .i_en      (bus.en[gi]),
        .i_sync    (bus.sync),
        .i_div     (bus.div[gi*CNT_W +: CNT_W]),
        .o_clk_out (w_clk_out[gi]),
        .o_tick    (w_tick[gi]),
        .o_active  (w_active[gi])
      );
    end
  endgenerate

  assign bus.clk_out = w_clk_out;
  assign bus.tick    = w_tick;
  assign bus.active  = w_active;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: per-cycle reference model plus directed
// period/duty measurements and randomized control traffic.
module tb_clk_div_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  clk_div_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: each running channel is at some position within a period of length d;
  // the level is high for the first ceil(d/2) positions and the tick marks position 0.
  bit          m_run [NUM_CH] = '{default: 1'b0};
  int unsigned m_pos [NUM_CH] = '{default: 0};
  int unsigned m_d   [NUM_CH] = '{default: 2};

  function automatic int unsigned san(input int unsigned v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst || !bus.en[c]) begin
        m_run[c] <= 1'b0;
        m_pos[c] <= 0;
      end else if (!m_run[c] || bus.sync || m_pos[c] == m_d[c] - 1) begin
        m_run[c] <= 1'b1;
        m_pos[c] <= 0;
        m_d[c]   <= san(int'(bus.div[c*CNT_W +: CNT_W]));
      end else begin
        m_pos[c] <= m_pos[c] + 1;
      end
    end
  end

  function automatic logic [NUM_CH-1:0] exp_vec(input int kind);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (kind)
        0:       v[c] = m_run[c];
        1:       v[c] = m_run[c] && (m_pos[c] == 0);
        default: v[c] = m_run[c] && (m_pos[c] < (m_d[c] + 1) / 2);
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    check_eq("model_active",  bus.active,  exp_vec(0));
    check_eq("model_tick",    bus.tick,    exp_vec(1));
    check_eq("model_clk_out", bus.clk_out, exp_vec(2));
  end

  task automatic set_div(input int c, input int unsigned v);
    bus.div[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  // Align to the next tick of channel c, then count one full period and its high cycles.
  task automatic measure(input int c, input int budget, output int per, output int hi, output int lo);
    int n;
    n = 0; per = 0; hi = 0; lo = 0;
    while (!bus.tick[c] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("ch%0d_tick_wait_timeout", c), longint'(n >= budget), 0);
    if (n >= budget) return;
    per = 1;
    hi  = int'(bus.clk_out[c]);
    @(negedge clk);
    while (!bus.tick[c] && per < budget) begin
      per++;
      hi += int'(bus.clk_out[c]);
      @(negedge clk);
    end
    lo = per - hi;
  endtask

  initial begin
    int per, hi, lo;
    int exp_per [4] = '{2, 3, 5, 1000};
    int exp_hi  [4] = '{1, 2, 3, 500};

    rst      = 1'b1;
    bus.en   = '1;
    bus.sync = 1'b0;
    bus.div  = '0;
    set_div(0, 2); set_div(1, 3); set_div(2, 5); set_div(3, 1000);
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {bus.clk_out, bus.tick, bus.active}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_tick",    bus.tick,    4'hF);
    check_eq("rel_clk_out", bus.clk_out, 4'hF);

    for (int c = 0; c < NUM_CH; c++) begin
      measure(c, 5000, per, hi, lo);
      check_eq($sformatf("ratio_ch%0d_period", c), per, exp_per[c]);
      check_eq($sformatf("ratio_ch%0d_high", c),   hi,  exp_hi[c]);
      check_eq($sformatf("ratio_ch%0d_low", c),    lo,  exp_per[c] - exp_hi[c]);
    end

    for (int v = 0; v < 2; v++) begin
      set_div(0, v);
      measure(0, 100, per, hi, lo);
      measure(0, 100, per, hi, lo);
      check_eq($sformatf("sanitize%0d_period", v), per, 2);
      check_eq($sformatf("sanitize%0d_high", v),   hi,  1);
    end

    set_div(0, 4);
    measure(0, 100, per, hi, lo);
    measure(0, 100, per, hi, lo);
    per = 1;
    @(negedge clk);
    set_div(0, 7);
    while (!bus.tick[0] && per < 100) begin
      per++;
      @(negedge clk);
    end
    check_eq("update_old_period", per, 4);
    measure(0, 100, per, hi, lo);
    check_eq("update_new_period", per, 7);
    check_eq("update_new_high",   hi,  4);
    check_eq("update_new_low",    lo,  3);

    bus.en = '0;
    set_div(0, 6); set_div(1, 6);
    @(negedge clk);
    bus.en = 4'b0001;
    repeat (2) @(negedge clk);
    bus.en = 4'b0011;
    repeat (3) @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    check_eq("sync_tick",     bus.tick,    4'b0011);
    check_eq("sync_idle_clk", bus.clk_out[2], 0);
    repeat (6) @(negedge clk);
    check_eq("sync_tick_next", bus.tick, 4'b0011);

    measure(1, 100, per, hi, lo);
    bus.en[1] = 1'b0;
    @(negedge clk);
    check_eq("disable_clk_out", bus.clk_out[1], 0);
    check_eq("disable_tick",    bus.tick[1],    0);
    check_eq("disable_active",  bus.active[1],  0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.en = NUM_CH'($urandom);
      if ($urandom_range(0, 3) == 0) set_div($urandom_range(0, NUM_CH - 1), $urandom_range(0, 12));
      bus.sync = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst      = 1'b0;
    bus.sync = 1'b0;

    bus.en = '0;
    @(negedge clk);
    set_div(3, 16'hFFFF);
    bus.en = 4'b1000;
    measure(3, 70000, per, hi, lo);
    check_eq("max_period", per, 65535);
    check_eq("max_high",   hi,  32768);
    check_eq("max_low",    lo,  32767);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Multi-channel programmable clock-enable/divided-clock generator for synthesizable logic, replacing free-running testbench-style toggling with counter-based division off the single system clock. Each of NUM_CH channels produces a 50%-nominal divided clock level and a one-cycle tick strobe at a runtime-programmable period, with per-channel enable, glitch-free ratio updates and a global phase-align input. It sits next to the clock/reset source and feeds slow peripherals, baud generators and test pattern logic.

## Interface
- NUM_CH, 4, number of independent channels (≥1)
- CNT_W, 16, counter/divisor width; max period 2^CNT_W−1 cycles
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  NUM_CH  per-channel enable, level
- div  in  NUM_CH*CNT_W  per-channel period in clk cycles, channel i at bits [i*CNT_W +: CNT_W]; values 0 and 1 treated as 2
- sync  in  1  global phase-align: restarts every enabled channel
- clk_out  out  NUM_CH  divided clock level, registered
- tick  out  NUM_CH  one-cycle strobe at start of each period (coincides with clk_out rising), registered
- active  out  NUM_CH  channel in RUN state

## Operation
- Per-channel states: IDLE, RUN. Reset value of all outputs 0; all channels IDLE, cnt=0, active_div=2.
- Sanitized divisor Ds = max(div_i, 2). High length H = ceil(D/2) = (D+1)>>1, computed in CNT_W+1 bits (no overflow at D=2^CNT_W−1).
- IDLE, en_i=1 sampled: → RUN; cnt←0, active_div←Ds, clk_out←1, tick←1.
- RUN, en_i=0 sampled: → IDLE; cnt←0, clk_out←0, tick←0 (high phase may be truncated; accepted).
- RUN, normal: if cnt==active_div−1: cnt←0, tick←1, clk_out←1, active_div←Ds (new divisor adopted only here). Else cnt←cnt+1, tick←0, clk_out←(cnt+1 < H).
- sync=1 with en_i=1 (either state): behaves as period start — cnt←0, active_div←Ds, clk_out←1, tick←1, state RUN. sync ignored for channels with en_i=0.
- Priority per edge: rst > en_i=0 > sync > wrap > count.
- div changes mid-period have no effect until next wrap or sync; no short/long glitch pulses.

## Timing
- Latency en/sync sampled high → clk_out=1, tick=1 on the next output cycle (1 clk).
- Steady state: tick period exactly D cycles; clk_out high H cycles, low D−H cycles. D=2: 1/1; D=5: 3/2.
- tick high exactly one cycle per period, never in IDLE.
- Reset mid-operation: all channels IDLE on next edge, outputs 0 regardless of en/sync.
- Channels fully independent except shared sync and rst.

## Structure
- Package clk_gen_pkg: CNT_W default, MIN_DIV=2 constant, channel state enum (IDLE, RUN), sanitize/high-length helper functions.
- Sub-module clk_div_ch (one channel: counter, active_div register, state, output registers); clk_div_gen instantiates NUM_CH via generate and slices div.

## Test plan
- Reset: rst=1 for 3 cycles with en=all 1 → clk_out, tick, active all 0; release → all channels tick on first cycle after release.
- Ratios: div={2,3,5,1000}, en=4'hF → tick periods 2,3,5,1000; clk_out high/low 1/1, 2/1, 3/2, 500/500.
- Sanitize: div=0 and div=1 on ch0 → identical to div=2 (toggle every cycle, tick every 2).
- Update: ch0 running div=4, change to 7 at cnt=1 → current period completes at 4 cycles, following periods 7; no intermediate pulse.
- Sync: ch0 div=6, ch1 div=6 enabled 2 cycles apart; pulse sync → both tick same cycle afterwards, ch2 (en=0) stays 0.
- Disable/max: disable ch1 during high phase → clk_out 0 next cycle, no tick; ch3 div=16'hFFFF → high 32768, low 32767, period 65535.
